e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the E-stage ALU and takes the same forwarded operands.
- Runs mult/multu/div/divu as multi-cycle operations and holds the HI/LO architectural registers.
- Serves mfhi/mflo/mthi/mtlo.
- Its busy/start outputs feed the hazard unit. MDU_out joins the E result mux going into the E/M pipeline register.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (≥1).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- MDU_A  input  32  operand rs (forwarded).
- MDU_B  input  32  operand rt (forwarded).
- MDUOp  input  4  op code: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; others behave as none.
- start  input  1  high in the E cycle of mult/multu/div/divu.
- Req  input  1  exception/interrupt request; suppresses any state change this cycle.
- busy  output  1  registered; high while an operation is in flight.
- HI_out  output  32  current HI.
- LO_out  output  32  current LO.
- MDU_out  output  32  combinational: HI if mfhi, LO if mflo, else 0.

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result cleared.
  - Reset mid-operation aborts it; no HI/LO write occurs.
- Accept condition at a posedge: start==1 && Req==0 && busy==0 && MDUOp ∈ {mult, multu, div, divu}.
  - Compute the 64-bit result from MDU_A/MDU_B and latch it into temp_hi/temp_lo.
  - Load counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - Set busy=1.
- States: IDLE (counter==0) and RUN (counter>0).
  - In RUN, each posedge decrements counter.
  - On the posedge where counter==1: HI<=temp_hi, LO<=temp_lo, counter<=0, busy<=0.
  - busy is therefore high for exactly N cycles after the accepting edge. HI/LO show the new values on the first cycle busy is low.
- start while busy: ignored. The hazard unit must stall on (busy|start) for any MDU op, so this case does not occur normally.
- mthi/mtlo, applied at a posedge only if Req==0 && busy==0:
  - mthi: HI<=MDU_A.
  - mtlo: LO<=MDU_A.
  - When busy: ignored.
- Req==1 at the accept edge: nothing starts, HI/LO unchanged, busy stays 0.
  - Req during RUN does not cancel the operation; it completes normally (the instruction was already committed past E).
- Arithmetic rules:
  - mult: signed 32x32 to 64-bit product {HI,LO}.
  - multu: unsigned 32x32 to 64-bit product {HI,LO}.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
- Boundary cases:
  - Divide by zero (MDU_B==0), div or divu: operation still occupies DIV_CYCLES with busy high, but HI/LO are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- MDU_out reads HI/LO registers combinationally. An mfhi/mflo issued in the cycle HI/LO are written therefore reads the old value. This cannot happen because the stall unit blocks mf* while busy|start.
- No overflow signalling; multiply/divide never raise an exception.

Test Plan:
- mult 0xFFFFFFFF × 0x00000002, start=1 one cycle:
  - busy high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands:
  - HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
  - mflo next cycle gives MDU_out=0xFFFFFFFE.
- div 0xFFFFFFF9 (−7) / 0x00000002:
  - busy high for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 0x00000007 / 0x00000000 with HI=0x11111111, LO=0x22222222 preloaded via mthi/mtlo:
  - busy high for 10 cycles.
  - HI/LO stay 0x11111111/0x22222222.
- mult with Req=1 at the start edge: busy stays 0, HI/LO unchanged.
- Separate case: reset driven low in RUN cycle 3 of a div:
  - busy=0 and HI=LO=0 immediately, asynchronously.
  - No later write after reset is released.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and runs mult/multu/div/divu
// as fixed-latency operations. The result is computed at accept and committed when the counter expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic        Req,
  output logic        busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MDU_out,
  output logic        dbg_state_o
);

  // Handshake: start is a one-cycle request with MDUOp/MDU_A/MDU_B. It is taken
  // only when busy is low and Req is low; busy then stays high for exactly N
  // cycles. A start arriving while busy is dropped, not queued.

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'h0,
    OP_MULT  = 4'h1,
    OP_MULTU = 4'h2,
    OP_DIV   = 4'h3,
    OP_DIVU  = 4'h4,
    OP_MFHI  = 4'h5,
    OP_MFLO  = 4'h6,
    OP_MTHI  = 4'h7,
    OP_MTLO  = 4'h8
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    tmp_hi_q, tmp_hi_d;
  logic [31:0]    tmp_lo_q, tmp_lo_d;
  logic           tmp_wr_q, tmp_wr_d;
  logic           busy_q, busy_d;

  logic           is_mul_op;
  logic           is_div_op;
  logic           accept;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               s_ovf;
  logic        [31:0] div_b;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  logic [31:0]    res_hi;
  logic [31:0]    res_lo;
  logic           res_wr;

  assign is_mul_op = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div_op = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign accept    = start && !Req && (state_q == S_IDLE) && (is_mul_op || is_div_op);

  assign prod_s = $signed({{32{MDU_A[31]}}, MDU_A}) * $signed({{32{MDU_B[31]}}, MDU_B});
  assign prod_u = {32'd0, MDU_A} * {32'd0, MDU_B};

  // Dividing by 1 instead of 0 or -1 keeps the divider free of X and overflow;
  // for 0x80000000 / -1 it also yields exactly the wrapped quotient and zero remainder.
  assign b_zero = (MDU_B == 32'd0);
  assign s_ovf  = (MDU_A == 32'h8000_0000) && (MDU_B == 32'hFFFF_FFFF);
  assign div_b  = (b_zero || s_ovf) ? 32'd1 : MDU_B;
  assign q_s    = $signed(MDU_A) / $signed(div_b);
  assign r_s    = $signed(MDU_A) % $signed(div_b);
  assign q_u    = MDU_A / div_b;
  assign r_u    = MDU_A % div_b;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (MDUOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
        res_wr = !b_zero;
      end
      OP_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
        res_wr = !b_zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    tmp_wr_d = tmp_wr_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_RUN;
          cnt_d    = is_mul_op ? MULT_LOAD : DIV_LOAD;
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          tmp_wr_d = res_wr;
          busy_d   = 1'b1;
        end else if (!Req && (MDUOp == OP_MTHI)) begin
          hi_d = MDU_A;
        end else if (!Req && (MDUOp == OP_MTLO)) begin
          lo_d = MDU_A;
        end
      end
      S_RUN: begin
        // Req is ignored here: the owning instruction has already left E.
        if (cnt_q == CNT_ONE) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          busy_d   = 1'b0;
          tmp_wr_d = 1'b0;
          if (tmp_wr_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      tmp_wr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      tmp_wr_q <= tmp_wr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    MDU_out = 32'd0;
    case (MDUOp)
      OP_MFHI: MDU_out = hi_q;
      OP_MFLO: MDU_out = lo_q;
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign HI_out      = hi_q;
  assign LO_out      = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO results, busy durations,
// move-to/from paths, Req suppression and asynchronous reset abort.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] MDU_A;
  logic [31:0] MDU_B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        Req;
  logic        busy;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic [31:0] MDU_out;
  logic        dbg_state_o;

  int checks   = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .MDU_A      (MDU_A),
    .MDU_B      (MDU_B),
    .MDUOp      (MDUOp),
    .start      (start),
    .Req        (Req),
    .busy       (busy),
    .HI_out     (HI_out),
    .LO_out     (LO_out),
    .MDU_out    (MDU_out),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    MDUOp = 4'h0;
    start = 1'b0;
    Req   = 1'b0;
    MDU_A = 32'd0;
    MDU_B = 32'd0;
  endtask

  // Drive one arithmetic op for one cycle, count busy cycles, check results.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    MDUOp = op; MDU_A = a; MDU_B = b; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    check_eq({tag, "_hi"}, HI_out, exp_hi);
    check_eq({tag, "_lo"}, LO_out, exp_lo);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a, input logic req);
    @(negedge clk);
    MDUOp = op; MDU_A = a; Req = req;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_hi", HI_out, 32'd0);
    check_eq("reset_lo", LO_out, 32'd0);
    check_eq("reset_state", 32'(dbg_state_o), 32'd0);
    reset = 1'b1;

    run_op("mult", 4'h1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'h2, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    MDUOp = 4'h6; #1;
    check_eq("mflo", MDU_out, 32'hFFFF_FFFE);
    MDUOp = 4'h5; #1;
    check_eq("mfhi", MDU_out, 32'h0000_0001);
    MDUOp = 4'h0; #1;
    check_eq("none_out", MDU_out, 32'd0);
    MDUOp = 4'hF; #1;
    check_eq("undef_out", MDU_out, 32'd0);
    MDUOp = 4'h0;

    run_op("div_neg", 4'h3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 4'h3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", 4'h4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("mult_min", 4'h1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);

    move_to(4'h7, 32'h1111_1111, 1'b0);
    move_to(4'h8, 32'h2222_2222, 1'b0);
    check_eq("mthi", HI_out, 32'h1111_1111);
    check_eq("mtlo", LO_out, 32'h2222_2222);
    move_to(4'h7, 32'hDEAD_BEEF, 1'b1);
    check_eq("mthi_req", HI_out, 32'h1111_1111);
    run_op("divu_zero", 4'h4, 32'h0000_0007, 32'h0000_0000, 10, 32'h1111_1111, 32'h2222_2222);
    run_op("div_zero", 4'h3, 32'hFFFF_FFF9, 32'h0000_0000, 10, 32'h1111_1111, 32'h2222_2222);

    // Req at the start edge blocks the accept
    @(negedge clk);
    MDUOp = 4'h1; MDU_A = 32'd3; MDU_B = 32'd4; start = 1'b1; Req = 1'b1;
    @(negedge clk);
    check_eq("req_start_busy", 32'(busy), 32'd0);
    idle_inputs();
    repeat (6) @(negedge clk);
    check_eq("req_start_hi", HI_out, 32'h1111_1111);
    check_eq("req_start_lo", LO_out, 32'h2222_2222);

    // mthi while busy is dropped; Req mid-run does not cancel; start while busy is dropped
    @(negedge clk);
    MDUOp = 4'h2; MDU_A = 32'h1234_5678; MDU_B = 32'h0000_0010; start = 1'b1;
    @(negedge clk);
    MDUOp = 4'h7; MDU_A = 32'hCAFE_F00D; start = 1'b0;
    @(negedge clk);
    check_eq("mthi_busy", HI_out, 32'h1111_1111);
    MDUOp = 4'h1; MDU_A = 32'd9; MDU_B = 32'd9; start = 1'b1; Req = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    check_eq("req_run_busy", 32'(busy), 32'd0);
    check_eq("req_run_hi", HI_out, 32'h0000_0001);
    check_eq("req_run_lo", LO_out, 32'h2345_6780);

    // asynchronous reset in RUN cycle 3 of a div
    @(negedge clk);
    MDUOp = 4'h3; MDU_A = 32'd100; MDU_B = 32'd7; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_busy", 32'(busy), 32'd0);
    check_eq("rst_async_hi", HI_out, 32'd0);
    check_eq("rst_async_lo", LO_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("rst_after_busy", 32'(busy), 32'd0);
    check_eq("rst_after_hi", HI_out, 32'd0);
    check_eq("rst_after_lo", LO_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
